// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for sync_fifo_param.
//   fifo_op_e : the operation accepted at a clock edge (push, pop, both, none)
//   ptr_w()   : pointer and count width for a given depth (address bits plus one wrap bit)
//   cfg_ok()  : legality of a parameter set, checked by the top at elaboration
// Optional feature macro used across the slice: SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit cfg_ok(input int data_w, input int depth,
                                 input int af, input int ae);
      return (data_w >= 1) && is_pow2(depth) &&
             (af >= 1) && (af <= depth) &&
             (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bus of sync_fifo_param.
//   write/iData      push request and data        (master -> slave)
//   read             pop request                  (master -> slave)
//   oData            pop data                     (slave -> master)
//   full/empty/almost_full/almost_empty/count     occupancy status (slave -> master)
//   overflow/underflow  one-cycle refusal pulses  (slave -> master)
// Handshake: write and read are requests, not valid/ready pairs. A push is
// accepted when not full, or when full and a pop is accepted at the same
// edge; a pop is accepted when not empty. A refused request is dropped and
// reported by overflow/underflow on the following cycle; nothing is retried.
interface sync_fifo_param_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) ();

   localparam int CW = ptr_w(DEPTH);

   logic              write;
   logic [DATA_W-1:0] iData;
   logic              read;
   logic [DATA_W-1:0] oData;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output write, iData, read,
      input  oData, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  write, iData, read,
      output oData, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port storage, DATA_W x DEPTH, synchronous write.
//   CLK          clock
//   RSTn         synchronous active-low reset of the read register (standard mode only)
//   re           read enable, loads the read register (standard mode only)
//   raddr        read address
//   rdata        read data: registered (standard) or combinational (FWFT)
//   we/waddr/wdata  write port
// SYNC_FIFO_FWFT_EN defined: combinational read so the head word is always
// visible. Undefined: registered read, one cycle latency, holds when re=0.
// The storage array itself is never reset.
module sync_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              CLK,
`ifndef SYNC_FIFO_FWFT_EN
   input  logic              RSTn,
   input  logic              re,
`endif
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem[raddr];
`else
   // Reading and writing the same address at one edge (full FIFO doing
   // push and pop together) returns the old word, which is the head.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
//   CLK    clock, all logic on the rising edge
//   RSTn   synchronous active-low reset
//   fifo   sync_fifo_param_if.slave: write/iData/read in; oData, full, empty,
//          almost_full, almost_empty, count, overflow, underflow out
// Parameters: DATA_W, DEPTH (power of two, >=2), AF_LEVEL (1..DEPTH),
// AE_LEVEL (0..DEPTH-1).
// Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output; undefined
// gives a registered output with one cycle read latency.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic           CLK,
   input  logic           RSTn,
   sync_fifo_param_if.slave fifo
);

   localparam int  PW     = ptr_w(DEPTH);
   localparam int  AW     = PW - 1;
   localparam bit  CFG_OK = cfg_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL);

   if (!CFG_OK) begin : g_cfg_err
      $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] count_q;
   logic [PW-1:0] count_nxt;
   logic          full_q;
   logic          empty_q;
   logic          afull_q;
   logic          aempty_q;
   logic          ovf_q;
   logic          unf_q;
   logic          wr_ok;
   logic          rd_ok;
   fifo_op_e      op;

   // A full FIFO still takes a push when the same edge pops a word.
   assign rd_ok = fifo.read & ~empty_q;
   assign wr_ok = fifo.write & (~full_q | rd_ok);
   assign op    = fifo_op_e'({wr_ok, rd_ok});

   always_comb begin
      count_nxt = count_q;
      case (op)
         OP_PUSH: count_nxt = count_q + 1'b1;
         OP_POP:  count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   // Flags are computed from the next count so they are registered yet
   // agree with count on every cycle.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count_q  <= count_nxt;
         full_q   <= (count_nxt == PW'(DEPTH));
         empty_q  <= (count_nxt == '0);
         afull_q  <= (count_nxt >= PW'(AF_LEVEL));
         aempty_q <= (count_nxt <= PW'(AE_LEVEL));
         ovf_q    <= fifo.write & ~wr_ok;
         unf_q    <= fifo.read & ~rd_ok;
      end
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .CLK   (CLK),
`ifndef SYNC_FIFO_FWFT_EN
      .RSTn  (RSTn),
      .re    (rd_ok),
`endif
      .raddr (rd_ptr[AW-1:0]),
      .rdata (fifo.oData),
      .we    (wr_ok),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (fifo.iData)
   );

   assign fifo.count        = count_q;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = afull_q;
   assign fifo.almost_empty = aempty_q;
   assign fifo.overflow     = ovf_q;
   assign fifo.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param (DATA_W=8, DEPTH=16,
// AF_LEVEL=14, AE_LEVEL=2). Works with or without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

   logic       clk;
   logic       rstn;
   int         n_cmp;
   int         n_fail;
   logic [7:0] exp_q [$];
   logic [7:0] q;

   sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) fifo ();

   sync_fifo_param #(
      .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut (
      .CLK  (clk),
      .RSTn (rstn),
      .fifo (fifo)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic hold_reset();
      rstn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   // ---------------- driver ----------------
   // One clock of stimulus. rd returns the word a pop delivered: in FWFT it
   // is the head shown before the edge, otherwise the register after it.
   task automatic step(input logic w, input logic [7:0] d, input logic r,
                       output logic [7:0] rd);
      fifo.write = w;
      fifo.iData = d;
      fifo.read  = r;
`ifdef SYNC_FIFO_FWFT_EN
      rd = fifo.oData;
`endif
      @(posedge clk); #1;
`ifndef SYNC_FIFO_FWFT_EN
      rd = fifo.oData;
`endif
      fifo.write = 1'b0;
      fifo.read  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      hold_reset();
      n_cmp++; if (fifo.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo.count); end
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo.empty); end
      n_cmp++; if (fifo.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", fifo.almost_empty); end
      n_cmp++; if (fifo.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo.full); end
      n_cmp++; if (fifo.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", fifo.almost_full); end
      n_cmp++; if ({fifo.overflow, fifo.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {fifo.overflow, fifo.underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (fifo.oData !== 8'h00) begin n_fail++; $display("FAIL reset_odata: got %h want 00", fifo.oData); end
`endif
   endtask

   task automatic test_fill_drain();
      logic [7:0] rd;
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b0, rd);
         n_cmp++; if (fifo.count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fifo.count, i); end
         n_cmp++; if (fifo.almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, fifo.almost_full, (i >= 14)); end
         n_cmp++; if (fifo.almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, fifo.almost_empty, (i <= 2)); end
         n_cmp++; if (fifo.full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, fifo.full, (i == 16)); end
      end
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1, rd);
         n_cmp++; if (rd !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd, 8'(i)); end
         n_cmp++; if (fifo.count !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, fifo.count, 16 - i); end
      end
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", fifo.empty); end
      n_cmp++; if (fifo.underflow !== 1'b0) begin n_fail++; $display("FAIL drain_unf: got %b want 0", fifo.underflow); end
   endtask

   task automatic test_overflow();
      logic [7:0] rd;
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, rd);
      step(1'b1, 8'hAA, 1'b0, rd);
      n_cmp++; if (fifo.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", fifo.overflow); end
      n_cmp++; if (fifo.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", fifo.count); end
      step(1'b0, 8'h00, 1'b0, rd);
      n_cmp++; if (fifo.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", fifo.overflow); end
      // Full with push and pop together: head 0x01 leaves, 0x11 joins.
      step(1'b1, 8'h11, 1'b1, rd);
      n_cmp++; if (rd !== 8'h01) begin n_fail++; $display("FAIL both_full_data: got %h want 01", rd); end
      n_cmp++; if (fifo.count !== 5'd16) begin n_fail++; $display("FAIL both_full_count: got %0d want 16", fifo.count); end
      n_cmp++; if ({fifo.full, fifo.overflow} !== 2'b10) begin n_fail++; $display("FAIL both_full_flags: got %b want 10", {fifo.full, fifo.overflow}); end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, rd);
         n_cmp++; if (rd !== ((i < 15) ? 8'(i + 2) : 8'h11)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, rd, ((i < 15) ? 8'(i + 2) : 8'h11)); end
      end
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty: got %b want 1", fifo.empty); end
   endtask

   task automatic test_underflow();
      logic [7:0] rd;
      logic [7:0] prev;
      prev = fifo.oData;
      step(1'b0, 8'h00, 1'b1, rd);
      n_cmp++; if (fifo.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b want 1", fifo.underflow); end
      n_cmp++; if (fifo.count !== 5'd0) begin n_fail++; $display("FAIL unf_count: got %0d want 0", fifo.count); end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (fifo.oData !== prev) begin n_fail++; $display("FAIL unf_odata_hold: got %h want %h", fifo.oData, prev); end
`endif
      step(1'b0, 8'h00, 1'b0, rd);
      n_cmp++; if (fifo.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_one_cycle: got %b want 0", fifo.underflow); end
      step(1'b1, 8'h55, 1'b1, rd);
      n_cmp++; if (fifo.underflow !== 1'b1) begin n_fail++; $display("FAIL empty_both_unf: got %b want 1", fifo.underflow); end
      n_cmp++; if (fifo.count !== 5'd1) begin n_fail++; $display("FAIL empty_both_count: got %0d want 1", fifo.count); end
      step(1'b0, 8'h00, 1'b1, rd);
      n_cmp++; if (rd !== 8'h55) begin n_fail++; $display("FAIL empty_both_data: got %h want 55", rd); end
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL empty_both_empty: got %b want 1", fifo.empty); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      logic [7:0] w;
      for (int i = 0; i < 5; i++) begin
         w = 8'h80 + 8'(i);
         step(1'b1, w, 1'b0, rd);
         exp_q.push_back(w);
      end
      for (int i = 0; i < 40; i++) begin
         w = 8'hC0 + 8'(i);
         step(1'b1, w, 1'b1, rd);
         exp_q.push_back(w);
         n_cmp++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd, exp_q[0]); end
         void'(exp_q.pop_front());
         n_cmp++; if (fifo.count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, fifo.count); end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] rd;
      for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, rd);
      n_cmp++; if (fifo.count !== 5'd9) begin n_fail++; $display("FAIL prereset_count: got %0d want 9", fifo.count); end
      // Requests during the reset edge must be ignored.
      rstn = 1'b0;
      fifo.write = 1'b1;
      fifo.read  = 1'b1;
      fifo.iData = 8'hEE;
      @(posedge clk); #1;
      rstn = 1'b1;
      fifo.write = 1'b0;
      fifo.read  = 1'b0;
      exp_q.delete();
      n_cmp++; if (fifo.count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", fifo.count); end
      n_cmp++; if ({fifo.empty, fifo.almost_empty} !== 2'b11) begin n_fail++; $display("FAIL midrst_empty: got %b want 11", {fifo.empty, fifo.almost_empty}); end
      n_cmp++; if ({fifo.full, fifo.almost_full} !== 2'b00) begin n_fail++; $display("FAIL midrst_full: got %b want 00", {fifo.full, fifo.almost_full}); end
      n_cmp++; if ({fifo.overflow, fifo.underflow} !== 2'b00) begin n_fail++; $display("FAIL midrst_pulses: got %b want 00", {fifo.overflow, fifo.underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (fifo.oData !== 8'h00) begin n_fail++; $display("FAIL midrst_odata: got %h want 00", fifo.oData); end
`endif
      step(1'b0, 8'h00, 1'b0, rd);
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_ignored: got %b want 1", fifo.empty); end
   endtask

   task automatic test_read_latency();
      logic [7:0] rd;
      step(1'b1, 8'h3C, 1'b0, rd);
      n_cmp++; if (fifo.empty !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got %b want 0", fifo.empty); end
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (fifo.oData !== 8'h3C) begin n_fail++; $display("FAIL lat_fwft_odata: got %h want 3c", fifo.oData); end
`else
      n_cmp++; if (fifo.oData !== 8'h00) begin n_fail++; $display("FAIL lat_std_hold: got %h want 00", fifo.oData); end
`endif
      step(1'b0, 8'h00, 1'b1, rd);
      n_cmp++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL lat_pop_data: got %h want 3c", rd); end
      n_cmp++; if (fifo.empty !== 1'b1) begin n_fail++; $display("FAIL lat_pop_empty: got %b want 1", fifo.empty); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      rstn       = 1'b1;
      fifo.write = 1'b0;
      fifo.read  = 1'b0;
      fifo.iData = 8'h00;
      #1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_mid_reset();
      test_read_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
